// File: rtl/fsm_pkg.sv
// ---------------------------------------------------------------------------
// fsm_pkg
// Shared definitions for the Mealy sequence FSM and its downstream symbol
// packer: the symbol width, the FSM output symbol codes, the packer state
// encoding and the width of the drop counter.
// No ports (package).
// ---------------------------------------------------------------------------
package fsm_pkg;

    localparam int SYM_W      = 2;
    localparam int DROP_CNT_W = 8;

    // Symbols emitted on the FSM Y output
    localparam logic [SYM_W-1:0] Y_00 = 2'b00;
    localparam logic [SYM_W-1:0] Y_01 = 2'b01;
    localparam logic [SYM_W-1:0] Y_10 = 2'b10;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_t;

endpackage

// File: rtl/y_symbol_packer_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high; clears the count
//   inc   - increment enable
//   count - current count value (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + {{(W-1){1'b0}}, 1'b1};
    end

endmodule

// File: rtl/y_symbol_packer.sv
// ---------------------------------------------------------------------------
// y_symbol_packer
// Collects the SYM_W-bit symbols produced by the sequence FSM and packs them
// LSB-first into SYMS_PER_WORD-symbol words presented on a valid/ready port.
// A packing register plus a one-word output register absorb one word of
// consumer back-pressure; symbols offered while stalled are dropped and
// counted. A level-sensitive flush emits the current partial word.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   sym_in, sym_valid    - incoming symbol and its qualifier
//   sym_ready            - symbol accepted this cycle (state FILL)
//   flush                - emit the current partial word
//   word_out, word_len   - packed word and number of valid symbols in it
//   word_valid, word_ready - output handshake
//   drop_cnt             - saturating count of dropped symbols
// ---------------------------------------------------------------------------
module y_symbol_packer
    import fsm_pkg::*;
#(
    parameter int SYMS_PER_WORD = 4,
    parameter int SYM_W         = fsm_pkg::SYM_W
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [SYM_W-1:0]                      sym_in,
    input  logic                                  sym_valid,
    output logic                                  sym_ready,
    input  logic                                  flush,
    output logic [SYM_W*SYMS_PER_WORD-1:0]        word_out,
    output logic [$clog2(SYMS_PER_WORD+1)-1:0]    word_len,
    output logic                                  word_valid,
    input  logic                                  word_ready,
    output logic [DROP_CNT_W-1:0]                 drop_cnt
);

    localparam int WORD_W = SYM_W * SYMS_PER_WORD;
    localparam int LEN_W  = $clog2(SYMS_PER_WORD + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(SYMS_PER_WORD);

    pack_state_t        state;
    logic [LEN_W-1:0]   cnt;
    logic [WORD_W-1:0]  pack_reg;

    logic               accept;
    logic               slot_free;
    logic               complete;
    logic [LEN_W-1:0]   eff_cnt;
    logic [WORD_W-1:0]  next_pack;

    // Ready depends on state alone so there is no path from word_ready.
    assign sym_ready = (state == FILL);

    // Next packing-register contents and word-completion decision. The
    // effective count includes a symbol accepted in this same cycle so that
    // a flush arriving with a symbol emits that symbol too.
    always_comb begin
        accept    = sym_valid && sym_ready;
        slot_free = !word_valid || word_ready;
        eff_cnt   = cnt + LEN_W'(accept);
        next_pack = pack_reg;
        if (accept)
            next_pack[int'(cnt)*SYM_W +: SYM_W] = sym_in;
        complete  = (state == FILL) &&
                    ((accept && (eff_cnt == FULL_LEN)) ||
                     (flush && (eff_cnt != '0)));
    end

    // Packer FSM. In FULL the finished word sits in pack_reg with its length
    // in cnt until the output register frees up.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            cnt        <= '0;
            pack_reg   <= '0;
            word_out   <= '0;
            word_len   <= '0;
            word_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (complete && slot_free) begin
                        word_out   <= next_pack;
                        word_len   <= eff_cnt;
                        word_valid <= 1'b1;
                        cnt        <= '0;
                        pack_reg   <= '0;
                    end else if (complete) begin
                        pack_reg   <= next_pack;
                        cnt        <= eff_cnt;
                        state      <= FULL;
                    end else begin
                        pack_reg   <= next_pack;
                        cnt        <= eff_cnt;
                        if (word_ready)
                            word_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (slot_free) begin
                        word_out   <= pack_reg;
                        word_len   <= cnt;
                        word_valid <= 1'b1;
                        cnt        <= '0;
                        pack_reg   <= '0;
                        state      <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    sat_counter #(
        .W(DROP_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sym_valid && !sym_ready),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_y_symbol_packer.sv
// ---------------------------------------------------------------------------
// tb_y_symbol_packer
// Directed self-checking bench for y_symbol_packer (N=4, SYM_W=2). Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_y_symbol_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sym_in = 2'b00;
    logic       sym_valid = 1'b0;
    logic       sym_ready;
    logic       flush = 1'b0;
    logic [7:0] word_out;
    logic [2:0] word_len;
    logic       word_valid;
    logic       word_ready = 1'b1;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    y_symbol_packer #(
        .SYMS_PER_WORD(4),
        .SYM_W        (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sym_in    (sym_in),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .flush     (flush),
        .word_out  (word_out),
        .word_len  (word_len),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, then step past the next rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] s,
                                 input logic f, input logic r);
        sym_valid  = v;
        sym_in     = s;
        flush      = f;
        word_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        reset = 1'b0;
    endtask

    logic [1:0] syms [8];
    logic       vexp [8];

    initial begin
        #1;
        // Reset state
        doReset();
        doReset();
        checkOutput("rst_valid", word_valid, 0);
        checkOutput("rst_out",   word_out,   0);
        checkOutput("rst_len",   word_len,   0);
        checkOutput("rst_drop",  drop_cnt,   0);
        checkOutput("rst_ready", sym_ready,  1);

        // Basic packing: 01,10,00,11 -> C9
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
        checkOutput("basic_v1", word_valid, 0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
        checkOutput("basic_v3", word_valid, 0);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
        checkOutput("basic_valid", word_valid, 1);
        checkOutput("basic_out",   word_out,   8'hC9);
        checkOutput("basic_len",   word_len,   4);
        checkOutput("basic_drop",  drop_cnt,   0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("basic_vfall", word_valid, 0);

        // Sustained stream: E4 then 4F on consecutive 4-cycle boundaries
        syms = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b01};
        vexp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("stream_rdy%0d", i), sym_ready, 1);
            applyStimulus(1'b1, syms[i], 1'b0, 1'b1);
            checkOutput($sformatf("stream_v%0d", i), word_valid, vexp[i]);
            if (i == 3) checkOutput("stream_w1", word_out, 8'hE4);
            if (i == 7) checkOutput("stream_w2", word_out, 8'h4F);
        end
        checkOutput("stream_drop", drop_cnt, 0);

        // Back-pressure: 55 held, EE waits in FULL, 4 drops
        doReset();
        for (int i = 0; i < 12; i++) begin
            if (i < 4)      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
            else if (i < 8) applyStimulus(1'b1, (i % 2 == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0);
            else            applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
            if (i >= 3) checkOutput($sformatf("bp_hold%0d", i), word_out, 8'h55);
            if (i == 6) checkOutput("bp_rdy_fill", sym_ready, 1);
            if (i == 7) checkOutput("bp_rdy_full", sym_ready, 0);
        end
        checkOutput("bp_valid", word_valid, 1);
        checkOutput("bp_drop",  drop_cnt,   4);
        checkOutput("bp_ready", sym_ready,  0);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("bp_w2_valid", word_valid, 1);
        checkOutput("bp_w2_out",   word_out,   8'hEE);
        checkOutput("bp_w2_len",   word_len,   4);
        checkOutput("bp_resume",   sym_ready,  1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("bp_done", word_valid, 0);

        // Flush of partial words
        doReset();
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
        checkOutput("fl_pre", word_valid, 0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
        checkOutput("fl_valid", word_valid, 1);
        checkOutput("fl_out",   word_out,   8'h07);
        checkOutput("fl_len",   word_len,   2);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b1);
        checkOutput("fl_empty", word_valid, 0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b1);
        checkOutput("fl3_valid", word_valid, 1);
        checkOutput("fl3_out",   word_out,   8'h18);
        checkOutput("fl3_len",   word_len,   3);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        checkOutput("fl3_fall", word_valid, 0);

        // Reset mid-word discards 11,11
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b10, 1'b0, 1'b1);
            if (i < 3) checkOutput($sformatf("mid_v%0d", i), word_valid, 0);
        end
        checkOutput("mid_valid", word_valid, 1);
        checkOutput("mid_out",   word_out,   8'hAA);
        checkOutput("mid_len",   word_len,   4);

        // Saturation: drops start at cycle 9, so 255 is reached after 263 edges
        doReset();
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
            if (i == 9)   checkOutput("sat_first", drop_cnt, 1);
            if (i == 262) checkOutput("sat_254",   drop_cnt, 254);
            if (i == 263) checkOutput("sat_255",   drop_cnt, 255);
        end
        checkOutput("sat_end",   drop_cnt,  255);
        checkOutput("sat_ready", sym_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/y_symbol_packer.md
# y_symbol_packer

Downstream stage of the 2-bit-output Mealy sequence FSM: collects the 2-bit `Y` symbols it emits every clock and packs them, LSB-first, into fixed-width words. Each word is presented on a valid/ready output port toward the byte sink or host interface. The block has a one-word output register and a packing register, so it absorbs one word of consumer back-pressure. A flush request emits partial words. Symbols offered while the block is stalled are dropped and counted, because the FSM upstream has no stall input.

## Interface
- `SYMS_PER_WORD`, default 4: symbols per output word; must be ≥ 2.
- `SYM_W`, default 2: symbol width; must match the FSM output width.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `sym_in` in `SYM_W`: symbol from the FSM `Y` output.
- `sym_valid` in 1: `sym_in` is meaningful this cycle; normally tied high.
- `sym_ready` out 1: block accepts `sym_in` this cycle.
- `flush` in 1: request to emit the current partial word.
- `word_out` out `SYM_W*SYMS_PER_WORD`: packed word; symbol i occupies bits `[SYM_W*i +: SYM_W]`.
- `word_len` out `$clog2(SYMS_PER_WORD+1)`: number of valid symbols in `word_out`, from 1 to `SYMS_PER_WORD`.
- `word_valid` out 1: `word_out` and `word_len` hold a word.
- `word_ready` in 1: consumer takes the word when `word_valid && word_ready`.
- `drop_cnt` out 8: saturating count of dropped symbols.

## Operation
- **Reset values:** `word_valid`=0, `word_out`=0, `word_len`=0, `drop_cnt`=0, state FILL, `cnt`=0, packing register cleared. `sym_ready`=1 in the first cycle after reset.
- **States:**
  - FILL: `cnt` < `SYMS_PER_WORD`; `sym_ready`=1.
  - FULL: a completed or flushed word is waiting in the packing register; `sym_ready`=0.
- **Slot free:** the output slot is free in a cycle when `!word_valid || word_ready`.
- **Accept:** a symbol is accepted when `sym_valid && sym_ready`. It is written at position `cnt`, then `cnt` increments.
- **Word completes** when the accepted symbol makes `cnt` reach N, or when `flush` is high in FILL with an effective count > 0. The effective count includes a symbol accepted in the same cycle.
  - Slot free: the packed word moves into the output register at that edge, with `word_len` = effective count. Unused upper symbol positions are 0. `cnt` returns to 0 and the state stays FILL.
  - Slot not free: the word and its length are held; the state goes to FULL.
- **FULL:** on the first cycle the slot is free, the word moves to the output, `cnt` returns to 0, and the state goes to FILL.
- **Flush edge cases:**
  - `flush` with effective count 0 is a no-op.
  - `flush` in FULL is ignored.
  - `flush` is level-sensitive, so holding it high emits every partial word.
- **Drop:** `sym_valid && !sym_ready` increments `drop_cnt`, which saturates at 255. The symbol is lost.
- **Output rules:** `word_out` and `word_len` are stable while `word_valid && !word_ready`. `word_valid` falls after a handshake unless a new word is loaded at the same edge.
- **Reset mid-operation:** reset overrides everything. The partial word and pending word are discarded, and `word_valid` goes to 0 at the next edge.

## Timing
- **Latency:** the last symbol of a word is accepted at edge k, and `word_valid` is high in cycle k+1 when the slot is free.
- **Throughput:** one symbol per cycle sustained, as long as the consumer accepts within every N cycles.
- **Back-to-back words:** a handshake and a new word load in the same cycle give continuous `word_valid` with no bubble.
- **Stall timing:** `sym_ready` drops in the cycle after entry to FULL, and rises in the cycle after the FULL→FILL transfer.
- **Combinational paths:** `sym_ready` is a function of state only, with no path from `word_ready`.

## Structure
- **Shared package `fsm_pkg`:**
  - `SYM_W`
  - FSM symbol constants (`Y_00`, `Y_01`, `Y_10`)
  - packer state enum (FILL, FULL)
  - `DROP_CNT_W` = 8
- **Sub-module:** one natural sub-module, `sat_counter` (parameterised width, increment enable, synchronous reset), used for `drop_cnt`. Everything else is inline.

## Test plan
- **Basic packing:** after reset, feed 01,10,00,11 with `word_ready`=1 → `word_valid` for one cycle with `word_out`=8'hC9, `word_len`=4, `drop_cnt`=0.
- **Sustained stream:** stream 8 symbols continuously with `word_ready`=1 → two words on consecutive 4-cycle boundaries; no drops, `sym_ready` always 1.
- **Back-pressure and drops:** hold `word_ready`=0 and stream 12 symbols.
  - Required: word 1 held stable, word 2 in FULL, `sym_ready`=0 from cycle 9, `drop_cnt`=4.
  - Then raise `word_ready` → both words delivered in order, FILL resumes.
- **Flush of a partial word:** feed 11,01 then pulse `flush` → `word_out`=8'h07, `word_len`=2.
  - A `flush` with `cnt`=0 → no word.
  - `flush` together with the 3rd symbol → `word_len`=3.
- **Reset mid-word:** feed 2 symbols, assert `reset` for 1 cycle, then feed 10,10,10,10 → single word 8'hAA, `word_len`=4; the partial word from before reset never appears.
- **Counter saturation:** hold `word_ready`=0 with `sym_valid`=1 for 300 cycles → `drop_cnt` saturates at 255 and never wraps.
